io_regbank: RTL and testbench

- Parametrised memory-mapped IO register bank for the soft-core data bus.
- Replaces the fixed 4-LED / 2-RGB / buttons / switches register array in the top level.
- Adds scalable channel counts, per-channel RGB PWM with glitch-free duty shadowing, sticky W1C edge-event capture for buttons and switches, and an optional button interrupt.
- Sits behind the top-level IO select; cmd_valid is asserted only for IO-space accesses.

---
 rtl/io_regbank_if.sv | 34 +++
 rtl/io_regbank.sv | 180 ++++++++++++++++++
 tb/tb_io_regbank.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_regbank_if.sv
// rtl/io_regbank_if.sv - command/response bus between the soft-core IO select and io_regbank
//
// Signals:
//   cmd_valid  single-cycle access request, always accepted
//   cmd_wr     1 = write, 0 = read
//   cmd_addr   byte address
//   cmd_be     write byte-lane enables
//   cmd_data   write data
//   rsp_valid  read data valid, one cycle after a read request
//   rsp_data   read data
//   rsp_error  unmapped read, qualified by rsp_valid
// Modports: master drives cmd_*, slave drives rsp_*.
interface io_regbank_if #(
   parameter int WL = 32
);
   logic            cmd_valid;
   logic            cmd_wr;
   logic [WL-1:0]   cmd_addr;
   logic [WL/8-1:0] cmd_be;
   logic [WL-1:0]   cmd_data;
   logic            rsp_valid;
   logic [WL-1:0]   rsp_data;
   logic            rsp_error;

   modport master (
      output cmd_valid, cmd_wr, cmd_addr, cmd_be, cmd_data,
      input  rsp_valid, rsp_data, rsp_error
   );

   modport slave (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_be, cmd_data,
      output rsp_valid, rsp_data, rsp_error
   );
endinterface

// File: rtl/io_regbank.sv
// rtl/io_regbank.sv - parametrised memory-mapped IO register bank with RGB PWM and edge events
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    io_regbank_if.slave command/response bus
//   btn    debounced buttons, synchronous to clk
//   sw     raw asynchronous switches
//   leds   LED drive, straight from the LEDS register
//   rgb    registered RGB outputs, channel k = rgb[3k+2:3k] = {b,g,r}
//   irq    level button interrupt
// Optional macro IO_REGBANK_IRQ_EN: enables BTN_IRQ_MASK at offset 4 and irq;
// when undefined offset 4 is reserved and irq is tied low.
module io_regbank #(
   parameter int CLK_FREQ = 100000000,
   parameter int PWM_FREQ = 20000,
   parameter int NUM_LEDS = 4,
   parameter int NUM_BTNS = 4,
   parameter int NUM_SWS  = 4,
   parameter int NUM_RGB  = 2,
   parameter int WL       = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   io_regbank_if.slave           bus,
   input  logic [NUM_BTNS-1:0]   btn,
   input  logic [NUM_SWS-1:0]    sw,
   output logic [NUM_LEDS-1:0]   leds,
   output logic [3*NUM_RGB-1:0]  rgb,
   output logic                  irq
);
   localparam int PWM_PERIOD = CLK_FREQ / PWM_FREQ;
   localparam int DC_WL      = $clog2(PWM_PERIOD + 1);
   localparam int NUM_REGS   = 8 + 2 * NUM_RGB;
   localparam int ADDR_WL    = $clog2(NUM_REGS);
   localparam int BW         = WL / 8;
   localparam logic [DC_WL-1:0] CNT_MAX = DC_WL'(PWM_PERIOD - 1);

   // Word index widened to 32 bits so the unmapped compare is exact even
   // when NUM_REGS is a power of two.
   logic [31:0]   idx32;
   logic [WL-1:0] wmask;
   logic [WL-1:0] wdat;
   logic          wr;
   logic          rd;

   assign idx32 = 32'(bus.cmd_addr[ADDR_WL+1:2]);
   assign wr    = bus.cmd_valid && bus.cmd_wr;
   assign rd    = bus.cmd_valid && !bus.cmd_wr;

   always_comb begin
      wmask = '0;
      for (int i = 0; i < BW; i++) wmask[8*i +: 8] = {8{bus.cmd_be[i]}};
   end
   assign wdat = bus.cmd_data & wmask;

   logic [NUM_LEDS-1:0] leds_r;
   logic [NUM_BTNS-1:0] btn_q, btn_evt;
   logic [NUM_SWS-1:0]  sw_s1, sw_s2, sw_q, sw_evt;
   logic [2:0]          color  [NUM_RGB];
   logic [DC_WL-1:0]    dcycle [NUM_RGB];
   logic [DC_WL-1:0]    active [NUM_RGB];
   logic [DC_WL-1:0]    cnt;
   logic [3*NUM_RGB-1:0] rgb_q;
   logic [NUM_BTNS-1:0] mask_rd;

   always_ff @(posedge clk) begin
      if (reset) begin
         leds_r  <= '0;
         btn_q   <= '0;
         btn_evt <= '0;
         sw_s1   <= '0;
         sw_s2   <= '0;
         sw_q    <= '0;
         sw_evt  <= '0;
         cnt     <= '0;
         rgb_q   <= '0;
         for (int k = 0; k < NUM_RGB; k++) begin
            color[k]  <= '0;
            dcycle[k] <= '0;
            active[k] <= '0;
         end
      end else begin
         btn_q <= btn;
         sw_s1 <= sw;
         sw_s2 <= sw_s1;
         sw_q  <= sw_s2;

         if (wr && idx32 == 32'd1)
            leds_r <= (leds_r & ~wmask[NUM_LEDS-1:0]) | wdat[NUM_LEDS-1:0];

         // The OR of the new edge comes after the clear, so a set landing in
         // the same cycle as its W1C survives.
         btn_evt <= (btn_evt & ~((wr && idx32 == 32'd3) ? wdat[NUM_BTNS-1:0] : '0))
                    | (btn & ~btn_q);
         sw_evt  <= (sw_evt & ~((wr && idx32 == 32'd6) ? wdat[NUM_SWS-1:0] : '0))
                    | (sw_s2 ^ sw_q);

         cnt <= (cnt == CNT_MAX) ? '0 : cnt + DC_WL'(1);

         for (int k = 0; k < NUM_RGB; k++) begin
            if (wr && idx32 == 32'(8 + 2*k))
               color[k] <= (color[k] & ~wmask[2:0]) | wdat[2:0];
            if (wr && idx32 == 32'(9 + 2*k))
               dcycle[k] <= (dcycle[k] & ~wmask[DC_WL-1:0]) | wdat[DC_WL-1:0];
            // Duty shadow only reloads at the period start, so a mid-period
            // write never produces a runt or stretched pulse.
            if (cnt == '0)
               active[k] <= dcycle[k];
            rgb_q[3*k +: 3] <= color[k] & {3{cnt < active[k]}};
         end
      end
   end

`ifdef IO_REGBANK_IRQ_EN
   logic [NUM_BTNS-1:0] irq_mask;
   logic                irq_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_mask <= '0;
         irq_q    <= 1'b0;
      end else begin
         if (wr && idx32 == 32'd4)
            irq_mask <= (irq_mask & ~wmask[NUM_BTNS-1:0]) | wdat[NUM_BTNS-1:0];
         irq_q <= |(btn_evt & irq_mask);
      end
   end

   assign mask_rd = irq_mask;
   assign irq     = irq_q;
`else
   assign mask_rd = '0;
   assign irq     = 1'b0;
`endif

   logic [WL-1:0] rd_data;
   logic          rd_err;

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      if (idx32 < 32'd8) begin
         case (idx32[2:0])
            3'd0: rd_data = WL'(32'h494F_0000 | 32'(NUM_RGB));
            3'd1: rd_data[NUM_LEDS-1:0] = leds_r;
            3'd2: rd_data[NUM_BTNS-1:0] = btn;
            3'd3: rd_data[NUM_BTNS-1:0] = btn_evt;
            3'd4: rd_data[NUM_BTNS-1:0] = mask_rd;
            3'd5: rd_data[NUM_SWS-1:0]  = sw_s2;
            3'd6: rd_data[NUM_SWS-1:0]  = sw_evt;
            default: rd_data = '0;
         endcase
      end else if (idx32 < 32'(NUM_REGS)) begin
         for (int k = 0; k < NUM_RGB; k++) begin
            if (idx32 == 32'(8 + 2*k)) rd_data[2:0]       = color[k];
            if (idx32 == 32'(9 + 2*k)) rd_data[DC_WL-1:0] = dcycle[k];
         end
      end else begin
         rd_err = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_error <= 1'b0;
      end else begin
         bus.rsp_valid <= rd;
         if (rd) begin
            bus.rsp_data  <= rd_data;
            bus.rsp_error <= rd_err;
         end
      end
   end

   assign leds = leds_r;
   assign rgb  = rgb_q;
endmodule

// File: tb/tb_io_regbank.sv
// tb/tb_io_regbank.sv - directed self-checking bench for io_regbank
module tb_io_regbank;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] btn;
   logic [3:0] sw;
   logic [3:0] leds;
   logic [5:0] rgb;
   logic       irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   io_regbank_if #(.WL(32)) bus ();

   io_regbank #(
      .CLK_FREQ(1000),
      .PWM_FREQ(100),
      .NUM_LEDS(4),
      .NUM_BTNS(4),
      .NUM_SWS (4),
      .NUM_RGB (2),
      .WL      (32)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus),
      .btn  (btn),
      .sw   (sw),
      .leds (leds),
      .rgb  (rgb),
      .irq  (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // All tasks start and end just after a falling edge.
   task automatic wr(input int word, input logic [31:0] data, input logic [3:0] be);
      bus.cmd_valid = 1'b1;
      bus.cmd_wr    = 1'b1;
      bus.cmd_addr  = 32'(word) << 2;
      bus.cmd_data  = data;
      bus.cmd_be    = be;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_wr    = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input int word, input logic [31:0] exp_d,
                         input logic exp_e);
      bus.cmd_valid = 1'b1;
      bus.cmd_wr    = 1'b0;
      bus.cmd_addr  = 32'(word) << 2;
      bus.cmd_be    = 4'h0;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_data"}, bus.rsp_data, exp_d);
      check({tag, "_err"}, 32'(bus.rsp_error), 32'(exp_e));
   endtask

   task automatic count_rgb0(input logic [2:0] pat, output int n);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rgb[2:0] == pat) n++;
      end
   endtask

   initial begin
      int   n;
      logic found;
      logic [2:0] s [20];

      reset         = 1'b1;
      btn           = 4'h0;
      sw            = 4'h0;
      bus.cmd_valid = 1'b1;
      bus.cmd_wr    = 1'b0;
      bus.cmd_addr  = 32'h0;
      bus.cmd_be    = 4'h0;
      bus.cmd_data  = 32'h0;

      // Reset with a read pending: no response, all outputs low.
      repeat (3) @(negedge clk);
      check("rst_leds", 32'(leds), 32'h0);
      check("rst_rgb", 32'(rgb), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("rst_rsp_data", bus.rsp_data, 32'h0);
      check("rst_rsp_error", 32'(bus.rsp_error), 32'h0);
      reset         = 1'b0;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'h0);

      rd_chk("id", 0, 32'h494F_0002, 1'b0);
      @(negedge clk);
      check("rsp_valid_drop", 32'(bus.rsp_valid), 32'h0);
      check("rsp_data_hold", bus.rsp_data, 32'h494F_0002);

      // LEDS byte lanes.
      wr(1, 32'hFFFF_FFFF, 4'b0001);
      check("leds_wr", 32'(leds), 32'hF);
      rd_chk("leds_rd", 1, 32'h0000_000F, 1'b0);
      wr(1, 32'h0, 4'b0000);
      check("leds_be0", 32'(leds), 32'hF);
      wr(1, 32'h0, 4'b0010);
      check("leds_be1", 32'(leds), 32'hF);

      // Button events: capture, set-wins-over-W1C, clear.
      btn = 4'h4;
      repeat (2) @(negedge clk);
      rd_chk("btn_evt", 3, 32'h4, 1'b0);
      rd_chk("btn_state", 2, 32'h4, 1'b0);
      rd_chk("btn_evt_reread", 3, 32'h4, 1'b0);
      btn = 4'h0;
      repeat (2) @(negedge clk);
      btn = 4'h4;
      wr(3, 32'h4, 4'hF);
      rd_chk("btn_set_wins", 3, 32'h4, 1'b0);
      wr(3, 32'h4, 4'hF);
      rd_chk("btn_w1c", 3, 32'h0, 1'b0);

      // Switch synchroniser and both-edge events.
      sw = 4'h2;
      repeat (4) @(negedge clk);
      rd_chk("sw_state", 5, 32'h2, 1'b0);
      rd_chk("sw_evt_rise", 6, 32'h2, 1'b0);
      wr(6, 32'h2, 4'hF);
      rd_chk("sw_w1c", 6, 32'h0, 1'b0);
      sw = 4'h0;
      repeat (4) @(negedge clk);
      rd_chk("sw_evt_fall", 6, 32'h2, 1'b0);

      // Reserved and unmapped offsets.
      rd_chk("reserved7", 7, 32'h0, 1'b0);
      rd_chk("unmapped12", 12, 32'h0, 1'b1);
      wr(12, 32'hFFFF_FFFF, 4'hF);
      rd_chk("unmapped_wr_leds", 1, 32'hF, 1'b0);
      rd_chk("unmapped_wr_color", 8, 32'h0, 1'b0);
      rd_chk("unmapped_wr_dcycle", 9, 32'h0, 1'b0);

      // PWM, period 10.
      wr(8, 32'h5, 4'hF);
      wr(9, 32'h3, 4'hF);
      rd_chk("dcycle_rd", 9, 32'h3, 1'b0);
      repeat (25) @(negedge clk);
      count_rgb0(3'b101, n);
      check("pwm_d3_on", 32'(n), 32'd3);
      count_rgb0(3'b000, n);
      check("pwm_d3_off", 32'(n), 32'd7);
      check("rgb1_off", 32'(rgb[5:3]), 32'h0);

      // Lock onto the start of a high phase, then change duty mid-period.
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (rgb[2:0] == 3'b000) found = 1'b1;
      end
      check("pwm_low_seen", 32'(found), 32'd1);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (rgb[2:0] != 3'b000) found = 1'b1;
      end
      check("pwm_rise_seen", 32'(found), 32'd1);
      wr(9, 32'd10, 4'hF);
      s[1] = rgb[2:0];
      for (int j = 2; j < 20; j++) begin
         @(negedge clk);
         s[j] = rgb[2:0];
      end
      check("pwm_d3_tail_on", 32'(s[2]), 32'h5);
      check("pwm_no_early_change", 32'(s[5]), 32'h0);
      n = 0;
      for (int j = 10; j < 20; j++) if (s[j] == 3'b101) n++;
      check("pwm_d10_full", 32'(n), 32'd10);

      // Colour change with duty always on: visible within two cycles.
      wr(8, 32'h2, 4'hF);
      @(negedge clk);
      check("color_latency", 32'(rgb[2:0]), 32'h2);

      wr(9, 32'h0, 4'hF);
      repeat (25) @(negedge clk);
      count_rgb0(3'b000, n);
      check("pwm_d0_off", 32'(n), 32'd10);

`ifdef IO_REGBANK_IRQ_EN
      wr(4, 32'h1, 4'hF);
      rd_chk("irq_mask_rd", 4, 32'h1, 1'b0);
      btn = 4'h5;
      @(negedge clk);
      check("irq_not_yet", 32'(irq), 32'h0);
      @(negedge clk);
      check("irq_set", 32'(irq), 32'h1);
      wr(3, 32'h1, 4'hF);
      @(negedge clk);
      check("irq_clr", 32'(irq), 32'h0);
`else
      wr(4, 32'h1, 4'hF);
      rd_chk("off4_reserved", 4, 32'h0, 1'b0);
      btn = 4'h5;
      repeat (3) @(negedge clk);
      check("irq_tied_low", 32'(irq), 32'h0);
      rd_chk("btn0_evt", 3, 32'h1, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
